adder_sequencer: RTL and testbench
==================================

# adder_sequencer

Multi-cycle controller that adds two WORDS×N-bit operands using a single shared `adder_n #(.N(N))` instance. It processes one N-bit slice per cycle, least-significant first, and chains the carry through a register. The block sits between a valid/ready requester and a valid/ready consumer. It lets wide additions run on the narrow adder already in the library without replicating it.

## Interface

**Parameters**
- `N`, default 8: width of the internal `adder_n` slice in bits.
- `WORDS`, default 4: number of slices per operand. Must be ≥ 1. Full operand width is W = N*WORDS.

**Ports**
- `clk`, input, 1: the single clock. All state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `i_valid`, input, 1: requester presents operands.
- `i_ready`, output, 1: block can accept operands. Equals (state == IDLE).
- `a`, input, W: operand A. Sampled only on accept.
- `b`, input, W: operand B. Sampled only on accept.
- `c_in`, input, 1: carry into slice 0. Sampled only on accept.
- `o_valid`, output, 1: result is available.
- `o_ready`, input, 1: consumer takes the result.
- `sum`, output, W: result, equal to (a + b + c_in) mod 2^W.
- `c_out`, output, 1: carry out of the most-significant slice.
- `busy`, output, 1: high while in ADD or DONE.

## Operation

**Registers**
- Latched operands `a_q` and `b_q` (W bits each).
- Carry register `carry_q`.
- Slice index `idx`, $clog2(WORDS) bits, minimum 1 bit.
- Result register `sum_q` (W bits) and `c_out_q`.
- 2-bit state register.

**Datapath**
- `adder_n` is driven from the registers, not from the ports:
  - `.a = a_q[idx*N +: N]`
  - `.b = b_q[idx*N +: N]`
  - `.c_in = carry_q`
- Port `sum` = `sum_q`. Port `c_out` = `c_out_q`.

**State machine**
- **IDLE**
  - `i_ready` = 1.
  - On `i_valid`: latch `a` into `a_q`, `b` into `b_q`, `c_in` into `carry_q`; set `idx` to 0; go to ADD.
  - Otherwise stay in IDLE.
- **ADD** (one slice per cycle)
  - Write the adder sum into `sum_q[idx*N +: N]`.
  - Load `carry_q` with the adder `c_out`.
  - If `idx == WORDS-1`: load `c_out_q` with the adder `c_out` and go to DONE.
  - Otherwise increment `idx`.
- **DONE**
  - `o_valid` = 1.
  - `sum_q` and `c_out_q` are held stable.
  - On `o_ready`: go to IDLE.
- The encoding for the unused state value decodes to IDLE on the next edge.

**Width rules**
- Slice k occupies bits [k*N+N-1 : k*N].
- No sign handling: operands are unsigned modulo 2^W.
- `c_out` is exactly bit W of (a + b + c_in).

## Timing

**Reset** (`rst` high at an edge):
- state = IDLE, `idx` = 0, `carry_q` = 0, `sum_q` = 0, `c_out_q` = 0.
- Outputs one cycle after reset: `o_valid` = 0, `busy` = 0, `i_ready` = 1, `sum` = 0, `c_out` = 0.

**Latency**
- Accept at edge T, meaning `i_valid && i_ready` is sampled at T.
- Edges T+1 .. T+WORDS perform the WORDS slice additions.
- `o_valid` is high after edge T+WORDS.
- With WORDS=1, `o_valid` rises after edge T+1.

**Handshakes**
- Input transfer occurs when `i_valid && i_ready`. Output transfer occurs when `o_valid && o_ready`.
- `i_ready` is 0 in both ADD and DONE. `i_valid` is ignored there and operands are not re-sampled.
- Throughput is one operation per WORDS+2 cycles with no stalls: accept cycle, WORDS ADD cycles, and at least one DONE cycle.
- There is no same-cycle DONE→accept path. A new request is accepted at the earliest on the cycle after the output transfer.

**Backpressure**
- With `o_ready` low, the block stays in DONE indefinitely.
- `sum` and `c_out` must not change during the stall.
- `o_valid` must not drop without a transfer.

**Other boundary conditions**
- **Port changes mid-operation:** changing `a`, `b`, or `c_in` after accept has no effect on the result.
- **Reset mid-ADD or mid-DONE:** the operation is aborted. No `o_valid` pulse occurs and the outputs take their reset values.
- **`rst` and `i_valid` together:** `rst` wins and the request is not accepted.
- **Slice index:** `idx` never exceeds WORDS-1. The carry into slice 0 is always the latched `c_in`.

## Test plan

Use N=8 and WORDS=4. The bench compares against the behavioural value a + b + c_in computed at (W+1) bits, using `===`.

1. **Zero add.** Reset, then a=0, b=0, c_in=0.
   - `o_valid` rises exactly 4 cycles after accept.
   - `sum` = 0x00000000, `c_out` = 0.
2. **Full carry ripple.** a=0xFFFFFFFF, b=0x00000001, c_in=0.
   - `sum` = 0x00000000, `c_out` = 1. This proves the carry crosses every slice boundary.
3. **Carry-in overflow.** a=0x7FFFFFFF, b=0x80000000, c_in=1.
   - `sum` = 0x00000000, `c_out` = 1.
4. **Stall and re-sample.** a=2, b=2, c_in=0, with `o_ready` held low for 3 cycles after `o_valid`, and a new `i_valid` with different operands held high throughout.
   - `sum` stays 4 and `o_valid` stays 1 during the stall.
   - `i_ready` stays 0 until after the transfer.
   - The second request is then accepted and produces its own correct result.
5. **Reset mid-operation.** Assert `rst` for 1 cycle at the 2nd ADD cycle.
   - Next cycle: `o_valid` = 0, `sum` = 0, `i_ready` = 1.
   - A following request (a=0x12345678, b=0x11111111, c_in=0) returns 0x23456789, `c_out` = 0.
6. **Random soak.** 200 random a/b/c_in values, with `i_valid` and `o_ready` randomly toggled each cycle.
   - Every transfer matches the behavioural result.
   - No transfer is dropped or duplicated.
   - Zero errors are reported.

Source files
------------

// File: rtl/adder_sequencer_if.sv
// Valid/ready request and response bundle for adder_sequencer.
// The requester/consumer side uses master; the sequencer uses slave.
interface adder_sequencer_if #(
  parameter int N     = 8,
  parameter int WORDS = 4
);
  localparam int W = N * WORDS;

  logic         i_valid;
  logic         i_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         o_valid;
  logic         o_ready;
  logic [W-1:0] sum;
  logic         c_out;
  logic         busy;

  modport master (
    output i_valid, a, b, c_in, o_ready,
    input  i_ready, o_valid, sum, c_out, busy
  );

  modport slave (
    input  i_valid, a, b, c_in, o_ready,
    output i_ready, o_valid, sum, c_out, busy
  );
endinterface

// File: rtl/adder_sequencer.sv
// Wide W = N*WORDS bit adder built from one shared N-bit adder slice,
// walking the slices LSB first with a registered carry chain.
module adder_n #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic [N-1:0] sum,
  output logic         c_out
);
  assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c_in};
endmodule

module adder_sequencer #(
  parameter int N     = 8,
  parameter int WORDS = 4
) (
  input  logic              clk,
  input  logic              rst,
  adder_sequencer_if.slave  bus
);
  localparam int W  = N * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  sum_q, sum_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          carry_q, carry_d;
  logic          c_out_q, c_out_d;

  logic [N-1:0]  slice_a_s;
  logic [N-1:0]  slice_b_s;
  logic [N-1:0]  slice_sum_s;
  logic          slice_c_s;

  // The shared slice adder only ever sees latched operands, never the ports.
  assign slice_a_s = a_q[int'(idx_q)*N +: N];
  assign slice_b_s = b_q[int'(idx_q)*N +: N];

  adder_n #(.N(N)) u_adder (
    .a     (slice_a_s),
    .b     (slice_b_s),
    .c_in  (carry_q),
    .sum   (slice_sum_s),
    .c_out (slice_c_s)
  );

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    c_out_d = c_out_q;
    case (state_q)
      IDLE: begin
        if (bus.i_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.c_in;
          idx_d   = {IW{1'b0}};
          state_d = ADD;
        end else begin
          state_d = IDLE;
        end
      end
      ADD: begin
        sum_d[int'(idx_q)*N +: N] = slice_sum_s;
        carry_d                   = slice_c_s;
        if (idx_q == IW'(WORDS - 1)) begin
          c_out_d = slice_c_s;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE: begin
        if (bus.o_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= {W{1'b0}};
      b_q     <= {W{1'b0}};
      sum_q   <= {W{1'b0}};
      idx_q   <= {IW{1'b0}};
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      c_out_q <= c_out_d;
    end
  end

  assign bus.i_ready = (state_q == IDLE);
  assign bus.o_valid = (state_q == DONE);
  assign bus.busy    = (state_q == ADD) || (state_q == DONE);
  assign bus.sum     = sum_q;
  assign bus.c_out   = c_out_q;
endmodule

// File: tb/tb_adder_sequencer.sv
// Randomized and directed bench for adder_sequencer, scored against
// a queue of (a + b + c_in) values computed at W+1 bits.
module tb_adder_sequencer;
  localparam int N     = 8;
  localparam int WORDS = 4;
  localparam int W     = N * WORDS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  adder_sequencer_if #(.N(N), .WORDS(WORDS)) bus ();

  adder_sequencer #(.N(N), .WORDS(WORDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_xfers  = 0;
  logic [W:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: inputs and state are stable at the falling edge, so the
  // handshakes seen here are the ones the next rising edge will commit.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (bus.i_valid && bus.i_ready)
        exp_q.push_back({1'b0, bus.a} + {1'b0, bus.b} + {{W{1'b0}}, bus.c_in});
      if (bus.o_valid && bus.o_ready) begin
        n_xfers++;
        if (exp_q.size() == 0) begin
          chk("xfer_unexpected", 64'd1, 64'd0);
        end else begin
          chk("xfer_result", {31'd0, bus.c_out, bus.sum}, {31'd0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!bus.o_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic take_output();
    bus.o_ready = 1'b1;
    @(posedge clk); #1;
    bus.o_ready = 1'b0;
  endtask

  // Issues one request from IDLE, checks latency and result, consumes it.
  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ci, input logic [W:0] exp);
    int lat;
    bus.a = a; bus.b = b; bus.c_in = ci; bus.i_valid = 1'b1;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    bus.a = ~a; bus.b = ~b; bus.c_in = ~ci;
    wait_valid(lat);
    chk({tag, "_lat"}, 64'(lat), 64'd4);
    chk({tag, "_sum"}, {31'd0, bus.c_out, bus.sum}, {31'd0, exp});
    take_output();
  endtask

  initial begin
    int lat;
    int cyc;
    bus.i_valid = 1'b0; bus.o_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.c_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_o_valid", 64'(bus.o_valid), 64'd0);
    chk("rst_busy",    64'(bus.busy),    64'd0);
    chk("rst_i_ready", 64'(bus.i_ready), 64'd1);
    chk("rst_sum",     64'(bus.sum),     64'd0);
    chk("rst_c_out",   64'(bus.c_out),   64'd0);

    do_op("zero",   32'h0000_0000, 32'h0000_0000, 1'b0, 33'h0_0000_0000);
    do_op("ripple", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 33'h1_0000_0000);
    do_op("cinovf", 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 33'h1_0000_0000);

    // Stall with a second request held valid throughout.
    bus.a = 32'd2; bus.b = 32'd2; bus.c_in = 1'b0; bus.i_valid = 1'b1;
    @(posedge clk); #1;
    bus.a = 32'd5; bus.b = 32'd7; bus.c_in = 1'b1;
    wait_valid(lat);
    chk("stall_lat", 64'(lat), 64'd4);
    for (int i = 0; i < 3; i++) begin
      chk("stall_sum",     64'(bus.sum),     64'd4);
      chk("stall_o_valid", 64'(bus.o_valid), 64'd1);
      chk("stall_i_ready", 64'(bus.i_ready), 64'd0);
      @(posedge clk); #1;
    end
    take_output();
    chk("post_xfer_i_ready", 64'(bus.i_ready), 64'd1);
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    wait_valid(lat);
    chk("second_lat", 64'(lat), 64'd4);
    chk("second_sum", {31'd0, bus.c_out, bus.sum}, 64'd13);
    take_output();

    // Reset during the second ADD cycle aborts the operation.
    bus.a = 32'hAAAA_AAAA; bus.b = 32'h5555_5555; bus.c_in = 1'b1; bus.i_valid = 1'b1;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_o_valid", 64'(bus.o_valid), 64'd0);
    chk("midrst_sum",     64'(bus.sum),     64'd0);
    chk("midrst_i_ready", 64'(bus.i_ready), 64'd1);
    chk("midrst_busy",    64'(bus.busy),    64'd0);
    repeat (6) begin
      chk("midrst_no_valid", 64'(bus.o_valid), 64'd0);
      @(posedge clk); #1;
    end

    // Reset wins over a simultaneous request.
    rst = 1'b1; bus.i_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; bus.i_valid = 1'b0;
    chk("rst_vs_valid_busy", 64'(bus.busy), 64'd0);

    do_op("postrst", 32'h1234_5678, 32'h1111_1111, 1'b0, 33'h0_2345_6789);

    // Random soak: random valid/ready each cycle, fresh operands each cycle.
    n_xfers = 0;
    begin
      int sent = 0;
      cyc = 0;
      while ((n_xfers < 200 || exp_q.size() != 0) && cyc < 20000) begin
        bus.i_valid = (sent < 200) ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.a       = $urandom;
        bus.b       = ($urandom_range(0, 3) == 0) ? ~bus.a : $urandom;
        bus.c_in    = 1'($urandom_range(0, 1));
        bus.o_ready = 1'($urandom_range(0, 1));
        if (bus.i_valid && bus.i_ready) sent++;
        @(posedge clk); #1;
        cyc++;
      end
      bus.i_valid = 1'b0; bus.o_ready = 1'b0;
      chk("soak_sent",    64'(sent),         64'd200);
      chk("soak_xfers",   64'(n_xfers),      64'd200);
      chk("soak_pending", 64'(exp_q.size()), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
